// File: rtl/cp0_reg_pkg.sv
// Shared CP0 constants: register numbers, ExcCodes, exception flag indices and vector.
package cp0_reg_pkg;

    localparam logic [31:0] EXC_ENTRY_DEFAULT = 32'hBFC0_0380;
    localparam logic [31:0] STATUS_RESET      = 32'h0040_0000;

    localparam logic [4:0] REG_BADVADDR = 5'd8;
    localparam logic [4:0] REG_COUNT    = 5'd9;
    localparam logic [4:0] REG_COMPARE  = 5'd11;
    localparam logic [4:0] REG_STATUS   = 5'd12;
    localparam logic [4:0] REG_CAUSE    = 5'd13;
    localparam logic [4:0] REG_EPC      = 5'd14;

    localparam int EXC_ADEL_IF = 0;
    localparam int EXC_ADEL_LD = 1;
    localparam int EXC_ADES    = 2;
    localparam int EXC_SYS     = 3;
    localparam int EXC_BP      = 4;
    localparam int EXC_RI      = 5;
    localparam int EXC_OV      = 6;

    localparam logic [4:0] CODE_INT  = 5'h00;
    localparam logic [4:0] CODE_ADEL = 5'h04;
    localparam logic [4:0] CODE_ADES = 5'h05;
    localparam logic [4:0] CODE_SYS  = 5'h08;
    localparam logic [4:0] CODE_BP   = 5'h09;
    localparam logic [4:0] CODE_RI   = 5'h0a;
    localparam logic [4:0] CODE_OV   = 5'h0c;

    // Lowest set flag index wins; an all-zero vector maps to Int.
    function automatic logic [4:0] exc_code(input logic [6:0] e);
        if (e[EXC_ADEL_IF] || e[EXC_ADEL_LD]) return CODE_ADEL;
        if (e[EXC_ADES]) return CODE_ADES;
        if (e[EXC_SYS])  return CODE_SYS;
        if (e[EXC_BP])   return CODE_BP;
        if (e[EXC_RI])   return CODE_RI;
        if (e[EXC_OV])   return CODE_OV;
        return CODE_INT;
    endfunction

endpackage

// File: rtl/cp0_reg_timer.sv
// Count/Compare timer: Count advances every second cycle, TI latches on a nonzero match.
module cp0_timer
    import cp0_reg_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        count_we,
    input  logic        compare_we,
    input  logic [31:0] wdata,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        ti
);

    logic toggle;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            toggle  <= 1'b0;
            count   <= '0;
            compare <= '0;
            ti      <= 1'b0;
        end else begin
            toggle <= ~toggle;
            if (count_we)
                count <= wdata;
            else if (toggle)
                count <= count + 32'd1;
            if (compare_we)
                compare <= wdata;
            // A Compare write wins over a match at the same edge.
            if (compare_we)
                ti <= 1'b0;
            else if (count == compare && compare != '0)
                ti <= 1'b1;
        end
    end

endmodule

// File: rtl/cp0_reg.sv
// CP0 register file and precise-exception/interrupt controller at the writeback boundary.
module cp0_reg
    import cp0_reg_pkg::*;
#(
    parameter logic [31:0] EXC_ENTRY = EXC_ENTRY_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_we,
    input  logic [4:0]  i_waddr,
    input  logic [31:0] i_wdata,
    input  logic [4:0]  i_raddr,
    input  logic [6:0]  i_except,
    input  logic        i_bd,
    input  logic        i_eret,
    input  logic [31:0] i_pc,
    input  logic [31:0] i_bad_addr,
    input  logic [5:0]  i_int,
    output logic [31:0] o_rdata,
    output logic        o_flush,
    output logic [31:0] o_new_pc,
    output logic [31:0] o_status,
    output logic [31:0] o_cause,
    output logic [31:0] o_epc,
    output logic        o_timer_int
);

    logic [7:0]  im;
    logic        exl, ie;
    logic        bd;
    logic [5:0]  ip_hw;
    logic [1:0]  ip_sw;
    logic [4:0]  exc_code_q;
    logic [31:0] epc, badvaddr;
    logic [31:0] count, compare;
    logic        ti;

    logic        int_pend, exc_valid, wr_ok;
    logic [4:0]  code;

    assign o_status = {9'b0, 1'b1, 6'b0, im, 6'b0, exl, ie};
    assign o_cause  = {bd, ti, 14'b0, ip_hw[5] | ti, ip_hw[4:0], ip_sw, 1'b0, exc_code_q, 2'b0};
    assign o_epc    = epc;
    assign o_timer_int = ti;

    assign int_pend  = ie & ~exl & (|(im & o_cause[15:8])) & (i_pc != '0);
    assign exc_valid = int_pend | (|i_except);
    assign code      = int_pend ? CODE_INT : exc_code(i_except);
    // An excepting instruction must not commit its mtc0.
    assign wr_ok     = i_we & ~exc_valid;

    assign o_flush  = exc_valid | i_eret;
    assign o_new_pc = exc_valid ? EXC_ENTRY : epc;

    cp0_timer u_timer (
        .clk        (clk),
        .reset      (reset),
        .count_we   (wr_ok && i_waddr == REG_COUNT),
        .compare_we (wr_ok && i_waddr == REG_COMPARE),
        .wdata      (i_wdata),
        .count      (count),
        .compare    (compare),
        .ti         (ti)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            im         <= '0;
            exl        <= 1'b0;
            ie         <= 1'b0;
            bd         <= 1'b0;
            ip_hw      <= '0;
            ip_sw      <= '0;
            exc_code_q <= '0;
            epc        <= '0;
            badvaddr   <= '0;
        end else begin
            ip_hw <= i_int;
            if (exc_valid) begin
                exc_code_q <= code;
                exl        <= 1'b1;
                if (!exl) begin
                    epc <= i_bd ? i_pc - 32'd4 : i_pc;
                    bd  <= i_bd;
                end
                if (!int_pend) begin
                    if (i_except[EXC_ADEL_IF])
                        badvaddr <= i_pc;
                    else if (i_except[EXC_ADEL_LD] || i_except[EXC_ADES])
                        badvaddr <= i_bad_addr;
                end
            end else begin
                if (wr_ok && i_waddr == REG_STATUS) begin
                    im  <= i_wdata[15:8];
                    exl <= i_wdata[1];
                    ie  <= i_wdata[0];
                end
                if (wr_ok && i_waddr == REG_CAUSE)
                    ip_sw <= i_wdata[9:8];
                if (wr_ok && i_waddr == REG_EPC)
                    epc <= i_wdata;
                if (i_eret)
                    exl <= 1'b0;
            end
        end
    end

    always_comb begin
        o_rdata = '0;
        case (i_raddr)
            REG_BADVADDR: o_rdata = badvaddr;
            REG_COUNT:    o_rdata = count;
            REG_COMPARE:  o_rdata = compare;
            REG_STATUS:   o_rdata = o_status;
            REG_CAUSE:    o_rdata = o_cause;
            REG_EPC:      o_rdata = epc;
            default:      o_rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_cp0_reg.sv
// Directed bench for cp0_reg: reset, exceptions, interrupts, eret and the timer.
module tb_cp0_reg;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_we;
    logic [4:0]  i_waddr;
    logic [31:0] i_wdata;
    logic [4:0]  i_raddr;
    logic [6:0]  i_except;
    logic        i_bd;
    logic        i_eret;
    logic [31:0] i_pc;
    logic [31:0] i_bad_addr;
    logic [5:0]  i_int;
    logic [31:0] o_rdata;
    logic        o_flush;
    logic [31:0] o_new_pc;
    logic [31:0] o_status;
    logic [31:0] o_cause;
    logic [31:0] o_epc;
    logic        o_timer_int;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    cp0_reg dut (
        .clk         (clk),
        .reset       (reset),
        .i_we        (i_we),
        .i_waddr     (i_waddr),
        .i_wdata     (i_wdata),
        .i_raddr     (i_raddr),
        .i_except    (i_except),
        .i_bd        (i_bd),
        .i_eret      (i_eret),
        .i_pc        (i_pc),
        .i_bad_addr  (i_bad_addr),
        .i_int       (i_int),
        .o_rdata     (o_rdata),
        .o_flush     (o_flush),
        .o_new_pc    (o_new_pc),
        .o_status    (o_status),
        .o_cause     (o_cause),
        .o_epc       (o_epc),
        .o_timer_int (o_timer_int)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        i_we = 0; i_waddr = 0; i_wdata = 0; i_except = 0; i_bd = 0;
        i_eret = 0; i_pc = 0; i_bad_addr = 0;
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        i_we = 1; i_waddr = a; i_wdata = d;
        tick();
        i_we = 0;
    endtask

    logic [31:0] prev_count;
    bit          seen;

    initial begin
        idle();
        i_raddr = 0; i_int = 0; reset = 1;
        repeat (2) @(posedge clk);
        #1 reset = 0;
        #1;
        check("rst_status", o_status, 32'h0040_0000);
        check("rst_cause", o_cause, 32'h0);
        check("rst_flush", {31'b0, o_flush}, 32'h0);
        check("rst_ti", {31'b0, o_timer_int}, 32'h0);
        i_raddr = 12;
        #1 check("rd_status", o_rdata, 32'h0040_0000);
        i_raddr = 9;
        tick(); tick();
        check("count_2cyc", o_rdata, 32'd1);
        tick(); tick();
        check("count_4cyc", o_rdata, 32'd2);
        i_raddr = 5;
        #1 check("rd_unmapped", o_rdata, 32'h0);

        // Syscall in a delay slot, with a same-cycle mtc0 to EPC that must be dropped.
        i_except = 7'h08; i_pc = 32'h8000_0100; i_bd = 1;
        i_we = 1; i_waddr = 14; i_wdata = 32'h0000_1234;
        #1;
        check("sys_flush", {31'b0, o_flush}, 32'h1);
        check("sys_newpc", o_new_pc, 32'hBFC0_0380);
        tick(); idle();
        check("sys_epc", o_epc, 32'h8000_00FC);
        check("sys_bd", {31'b0, o_cause[31]}, 32'h1);
        check("sys_code", {27'b0, o_cause[6:2]}, 32'h08);
        check("sys_exl", {31'b0, o_status[1]}, 32'h1);

        // AdES while EXL=1: EPC/BD hold, BadVAddr captured.
        i_except = 7'h04; i_pc = 32'h8000_0300; i_bad_addr = 32'h0000_0003;
        tick(); idle();
        i_raddr = 8;
        #1;
        check("ades_epc", o_epc, 32'h8000_00FC);
        check("ades_bd", {31'b0, o_cause[31]}, 32'h1);
        check("ades_bva", o_rdata, 32'h0000_0003);
        check("ades_code", {27'b0, o_cause[6:2]}, 32'h05);

        // Interrupt vs Ov: interrupt wins.
        mtc0(12, 32'h0000_0401);
        check("int_status", o_status, 32'h0040_0401);
        i_int = 6'h01;
        tick();
        check("int_ip", {31'b0, o_cause[10]}, 32'h1);
        check("int_bubble", {31'b0, o_flush}, 32'h0);
        i_pc = 32'h8000_0200; i_except = 7'h40;
        #1 check("int_flush", {31'b0, o_flush}, 32'h1);
        tick(); idle();
        i_int = 0;
        check("int_code", {27'b0, o_cause[6:2]}, 32'h00);
        check("int_epc", o_epc, 32'h8000_0200);
        check("int_exl", {31'b0, o_status[1]}, 32'h1);

        // eret
        mtc0(14, 32'h8000_0040);
        check("eret_epcw", o_epc, 32'h8000_0040);
        i_eret = 1;
        #1;
        check("eret_flush", {31'b0, o_flush}, 32'h1);
        check("eret_newpc", o_new_pc, 32'h8000_0040);
        tick(); idle();
        check("eret_exl", {31'b0, o_status[1]}, 32'h0);

        // eret together with RI: exception path wins.
        i_eret = 1; i_except = 7'h20; i_pc = 32'h8000_0500;
        #1 check("eretri_newpc", o_new_pc, 32'hBFC0_0380);
        tick(); idle();
        check("eretri_code", {27'b0, o_cause[6:2]}, 32'h0a);
        check("eretri_exl", {31'b0, o_status[1]}, 32'h1);
        check("eretri_epc", o_epc, 32'h8000_0500);

        // Timer
        i_raddr = 9;
        mtc0(9, 32'h0);
        check("cnt_write", o_rdata, 32'h0);
        mtc0(11, 32'd10);
        seen = 0;
        prev_count = o_rdata;
        for (int i = 0; i < 60 && !seen; i++) begin
            prev_count = o_rdata;
            tick();
            if (o_timer_int) seen = 1;
        end
        check("ti_seen", {31'b0, seen}, 32'h1);
        check("ti_at_count", prev_count, 32'd10);
        check("ti_cause30", {31'b0, o_cause[30]}, 32'h1);
        check("ti_ip7", {31'b0, o_cause[15]}, 32'h1);
        mtc0(11, 32'd200);
        check("ti_clear", {31'b0, o_timer_int}, 32'h0);

        // Asynchronous reset mid-run.
        #2 reset = 1;
        #1;
        check("arst_status", o_status, 32'h0040_0000);
        check("arst_epc", o_epc, 32'h0);
        check("arst_count", o_rdata, 32'h0);
        tick();
        reset = 0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cp0_reg.md
# cp0_reg

Coprocessor-0 register file and precise-exception controller for the 5-stage MIPS32 core. Sits directly downstream of the MEM/WB pipeline register and consumes its `o_mtc0_we`, `o_c0_addr`, `o_c0_wdata`, `o_except`, `o_bd`, `o_eret` and `o_pc` outputs. Holds BadVAddr, Count, Compare, Status, Cause and EPC, and runs the Count/Compare timer. It arbitrates interrupts against synchronous exceptions and drives pipeline flush plus the redirect PC.

## Interface
- `EXC_ENTRY`, default 32'hBFC0_0380, exception vector (Status.BEV=1)
- `clk`  in  1  core clock
- `reset`  in  1  asynchronous, active-high reset
- `i_we`  in  1  mtc0 write enable (from MEM/WB)
- `i_waddr`  in  5  CP0 register number for the write
- `i_wdata`  in  32  write data
- `i_raddr`  in  5  CP0 register number for the mfc0 read
- `i_except`  in  7  exception flags: [0] AdEL-fetch, [1] AdEL-load, [2] AdES, [3] Syscall, [4] Break, [5] RI, [6] Ov
- `i_bd`  in  1  faulting instruction is in a delay slot
- `i_eret`  in  1  eret retiring
- `i_pc`  in  32  PC of the retiring instruction; 0 marks a bubble
- `i_bad_addr`  in  32  faulting virtual address for AdEL/AdES
- `i_int`  in  6  hardware interrupt lines, level-sensitive
- `o_rdata`  out  32  mfc0 read data
- `o_flush`  out  1  flush all pipeline registers
- `o_new_pc`  out  32  redirect target, valid when `o_flush`=1
- `o_status`, `o_cause`, `o_epc`  out  32  current register values
- `o_timer_int`  out  1  Cause.TI

## Operation
- Register numbers: BadVAddr 8, Count 9, Compare 11, Status 12, Cause 13, EPC 14. Any other number reads 0 and ignores writes.
- Writable fields:
  - Status IM[15:8], EXL[1], IE[0]; all other Status bits read constant (BEV[22]=1).
  - Cause IP[9:8] (software interrupts).
  - Count, Compare and EPC: full 32 bits.
- Cause IP[15:10] = `i_int` sampled every cycle. IP[15] is ORed with TI.
- Timer:
  - Count increments by 1 every second cycle, using an internal toggle bit.
  - When Count == Compare and Compare != 0, TI is set.
  - A write to Compare clears TI.
  - Both Count and Compare wrap mod 2^32.
- Interrupt pending = Status.IE & ~Status.EXL & |(Status.IM & Cause.IP) & (`i_pc` != 0).
- Event priority, highest first: interrupt, then `i_except` bit 0→6 (lowest index wins), then eret.
- ExcCode per event: Int 0x00; bit0/bit1 → 0x04; bit2 → 0x05; bit3 → 0x08; bit4 → 0x09; bit5 → 0x0a; bit6 → 0x0c.
- On an exception or interrupt:
  - `o_flush`=1 and `o_new_pc`=`EXC_ENTRY`.
  - Next edge writes Cause.ExcCode.
  - If EXL was 0: EPC ← `i_bd` ? `i_pc`-4 : `i_pc`; Cause.BD ← `i_bd`; EXL ← 1.
  - If EXL was 1: EPC and BD are unchanged.
  - AdEL-fetch: BadVAddr ← `i_pc`. AdEL-load/AdES: BadVAddr ← `i_bad_addr`.
  - An mtc0 in the same cycle is suppressed.
- On eret with no exception: `o_flush`=1, `o_new_pc`=EPC, next edge EXL ← 0.
- `o_rdata` is a combinational read of the current register state, with no write bypass.

## Timing
- Reset values:
  - Status = 32'h0040_0000; Cause, EPC, BadVAddr, Count, Compare = 0; toggle bit = 0.
  - Every output follows from these values: `o_flush`=0, `o_timer_int`=0.
- `o_flush` and `o_new_pc` are combinational in the cycle the event appears at the inputs. All register updates land on the following rising edge.
- An mtc0 to Count takes priority over that cycle's increment.
- An mtc0 to Compare at the same edge as a Count==Compare match leaves TI cleared.
- Reset asserted mid-operation clears all state immediately. The first event is accepted on the first edge after release.

## Structure
- Shared package/header holds the CP0 register numbers, ExcCode constants, the `i_except` bit indices and `EXC_ENTRY`.
- Natural sub-module: `cp0_timer` (Count, Compare, toggle bit, TI).

## Test plan
- Reset, then read Status/Cause → 32'h0040_0000 / 0. Count = 1 after 2 cycles and 2 after 4 cycles.
- Syscall: `i_except`=7'h08, `i_pc`=32'h8000_0100, `i_bd`=1 → flush, new_pc 32'hBFC0_0380. Next edge: EPC = 32'h8000_00FC, Cause.BD=1, ExcCode 0x08, EXL=1.
- AdES with `i_bad_addr`=32'h0000_0003 while EXL=1 → EPC unchanged, BadVAddr=3, ExcCode 0x05.
- Set IE=1, IM[10]=1, assert `i_int[0]` with `i_pc`=32'h8000_0200 together with an Ov flag → interrupt wins, ExcCode 0x00.
- Write Compare=10, wait for Count to reach 10 → TI=1 and `o_timer_int`=1. Write Compare again → TI=0.
- eret with EPC=32'h8000_0040 → flush, new_pc 32'h8000_0040, EXL=0. eret together with RI → exception path taken, ExcCode 0x0a.
